rf_registry: RTL and testbench

Multi-channel hardware attribute registry for the reflection layer: up to NUM_CH requesters set or get named attribute values held in a DEPTH-entry table. Each request is identified by a NAME_W-bit name hash. A single scan engine serves requests one at a time under round-robin arbitration and walks the table one entry per cycle. A tagged response bus returns value, hit, index and error status.

---
 rtl/rf_registry_pkg.sv | 28 ++
 rtl/rf_registry_if.sv | 39 +++
 rtl/rf_rr_arbiter.sv | 31 +++
 rtl/rf_registry.sv | 214 +++++++++++++++++++++
 tb/tb_rf_registry.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_registry_pkg.sv
// rtl/rf_registry_pkg.sv - shared types and defaults for the attribute registry
package rf_registry_pkg;

    localparam int RF_NUM_CH = 2;
    localparam int RF_DEPTH  = 16;
    localparam int RF_NAME_W = 16;
    localparam int RF_DATA_W = 32;

    typedef enum logic {
        RF_GET = 1'b0,
        RF_SET = 1'b1
    } rf_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } rf_state_t;

    // Default-width table entry layout; the top declares the same layout
    // against its own parameters so non-default widths stay consistent.
    typedef struct packed {
        logic                 valid;
        logic [RF_NAME_W-1:0] name;
        logic [RF_DATA_W-1:0] value;
    } rf_entry_t;

endpackage

// File: rtl/rf_registry_if.sv
// rtl/rf_registry_if.sv - request/response bus between requesters and the registry
interface rf_registry_if #(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 16,
    parameter int NAME_W = 16,
    parameter int DATA_W = 32
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = $clog2(DEPTH);

    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        req_op;
    logic [NUM_CH*NAME_W-1:0] req_name;
    logic [NUM_CH*DATA_W-1:0] req_data;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [CH_W-1:0]          rsp_ch;
    logic                     rsp_hit;
    logic                     rsp_err;
    logic [IDX_W-1:0]         rsp_idx;
    logic [DATA_W-1:0]        rsp_data;

    logic [IDX_W:0]           num_entries;

    modport master (
        output req_valid, req_op, req_name, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_ch, rsp_hit, rsp_err, rsp_idx,
               rsp_data, num_entries
    );

    modport slave (
        input  req_valid, req_op, req_name, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_ch, rsp_hit, rsp_err, rsp_idx,
               rsp_data, num_entries
    );

endinterface

// File: rtl/rf_rr_arbiter.sv
// rtl/rf_rr_arbiter.sv - round-robin request arbiter starting at a supplied pointer
module rf_rr_arbiter #(
    parameter int  NUM_CH = 2,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              any
);

    function automatic int wrap_ch(input int a);
        return (a >= NUM_CH) ? (a - NUM_CH) : a;
    endfunction

    // Walk channels from ptr upward, wrapping; the first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!any && req[wrap_ch(int'(ptr) + i)]) begin
                any                         = 1'b1;
                grant[wrap_ch(int'(ptr) + i)] = 1'b1;
                grant_idx                   = CH_W'(wrap_ch(int'(ptr) + i));
            end
        end
    end

endmodule

// File: rtl/rf_registry.sv
// rtl/rf_registry.sv - multi-channel name-hash attribute registry with a serial scan engine
module rf_registry
    import rf_registry_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 16,
    parameter int NAME_W = 16,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    rf_registry_if.slave bus
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic              valid;
        logic [NAME_W-1:0] name;
        logic [DATA_W-1:0] value;
    } entry_t;

    rf_state_t         state_q, state_d;
    logic [CH_W-1:0]   rr_ptr_q;

    rf_op_t            op_q;
    logic [NAME_W-1:0] name_q;
    logic [DATA_W-1:0] data_q;
    logic [CH_W-1:0]   ch_q;
    logic [IDX_W-1:0]  idx_q;
    logic              free_found_q;
    logic [IDX_W-1:0]  free_idx_q;

    entry_t            tbl_q [DEPTH];
    logic [CNT_W-1:0]  count_q;

    logic [CH_W-1:0]   rsp_ch_q;
    logic              rsp_hit_q;
    logic              rsp_err_q;
    logic [IDX_W-1:0]  rsp_idx_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_any;
    logic              accept;

    logic              sel_op;
    logic [NAME_W-1:0] sel_name;
    logic [DATA_W-1:0] sel_data;

    entry_t            cur;
    logic              match;
    logic              last;
    logic              free_now;
    logic [IDX_W-1:0]  free_idx_now;
    logic              scan_done;

    rf_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Pick the granted channel's request fields out of the packed buses.
    always_comb begin
        sel_op   = 1'b0;
        sel_name = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == CH_W'(i)) begin
                sel_op   = bus.req_op[i];
                sel_name = bus.req_name[i*NAME_W +: NAME_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Per-cycle scan evaluation of the entry under the scan index. A free
    // slot found on the final entry itself still counts for allocation.
    always_comb begin
        cur          = tbl_q[idx_q];
        match        = cur.valid && (cur.name == name_q);
        last         = (idx_q == IDX_W'(DEPTH - 1));
        free_now     = free_found_q || ((op_q == RF_SET) && !cur.valid);
        free_idx_now = free_found_q ? free_idx_q : idx_q;
        scan_done    = (state_q == ST_SCAN) && (match || last);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and accept decode; grants only happen while idle, so the
    // response handshake cycle never overlaps a new accept.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    accept  = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (match || last) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, scan progress, table update and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            op_q         <= RF_GET;
            name_q       <= '0;
            data_q       <= '0;
            ch_q         <= '0;
            idx_q        <= '0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
            count_q      <= '0;
            rsp_ch_q     <= '0;
            rsp_hit_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_idx_q    <= '0;
            rsp_data_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                op_q         <= rf_op_t'(sel_op);
                name_q       <= sel_name;
                data_q       <= sel_data;
                ch_q         <= grant_idx;
                idx_q        <= '0;
                free_found_q <= 1'b0;
                rr_ptr_q     <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0
                                                                  : grant_idx + CH_W'(1);
            end

            if ((state_q == ST_SCAN) && !scan_done) begin
                idx_q <= idx_q + IDX_W'(1);
                if ((op_q == RF_SET) && !cur.valid && !free_found_q) begin
                    free_found_q <= 1'b1;
                    free_idx_q   <= idx_q;
                end
            end

            if (scan_done) begin
                rsp_ch_q <= ch_q;
                if (match) begin
                    rsp_hit_q <= 1'b1;
                    rsp_err_q <= 1'b0;
                    rsp_idx_q <= idx_q;
                    if (op_q == RF_SET) begin
                        tbl_q[idx_q].value <= data_q;
                        rsp_data_q         <= data_q;
                    end else begin
                        rsp_data_q <= cur.value;
                    end
                end else if (op_q == RF_GET) begin
                    rsp_hit_q  <= 1'b0;
                    rsp_err_q  <= 1'b0;
                    rsp_idx_q  <= '0;
                    rsp_data_q <= '0;
                end else if (free_now) begin
                    tbl_q[free_idx_now] <= '{valid: 1'b1, name: name_q, value: data_q};
                    rsp_hit_q  <= 1'b0;
                    rsp_err_q  <= 1'b0;
                    rsp_idx_q  <= free_idx_now;
                    rsp_data_q <= data_q;
                    if (count_q < CNT_W'(DEPTH)) begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end else begin
                    rsp_hit_q  <= 1'b0;
                    rsp_err_q  <= 1'b1;
                    rsp_idx_q  <= '0;
                    rsp_data_q <= '0;
                end
            end
        end
    end

    assign bus.req_ready   = accept ? grant : '0;
    assign bus.rsp_valid   = (state_q == ST_RESP);
    assign bus.rsp_ch      = rsp_ch_q;
    assign bus.rsp_hit     = rsp_hit_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_idx     = rsp_idx_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.num_entries = count_q;

endmodule

// File: tb/tb_rf_registry.sv
// tb/tb_rf_registry.sv - directed self-checking bench for rf_registry
module tb_rf_registry;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 16;
    localparam int NAME_W = 16;
    localparam int DATA_W = 32;
    localparam int MISS_LAT = DEPTH + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_registry_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .NAME_W(NAME_W), .DATA_W(DATA_W)) bus ();

    rf_registry #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .NAME_W(NAME_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    // Issue one request, return at the negedge where rsp_valid is first seen.
    task automatic do_req(input int ch, input bit op, input logic [15:0] name,
                          input logic [31:0] data, output int lat, output int wait_acc);
        int t0;
        lat      = 0;
        wait_acc = 0;
        @(negedge clk);
        bus.req_valid[ch]                    = 1'b1;
        bus.req_op[ch]                       = op;
        bus.req_name[ch*NAME_W +: NAME_W]    = name;
        bus.req_data[ch*DATA_W +: DATA_W]    = data;
        #1;
        while (!bus.req_ready[ch] && wait_acc < 50) begin
            @(negedge clk);
            #1;
            wait_acc++;
        end
        if (!bus.req_ready[ch]) begin
            check("accept_timeout", 64'(bus.req_ready[ch]), 64'd1);
            bus.req_valid[ch] = 1'b0;
            return;
        end
        t0 = cyc;
        @(posedge clk);
        #1 bus.req_valid[ch] = 1'b0;
        @(negedge clk);
        while (!bus.rsp_valid && (cyc - t0) < 100) @(negedge clk);
        if (!bus.rsp_valid) check("rsp_timeout", 64'(bus.rsp_valid), 64'd1);
        lat = cyc - t0;
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input int lat, input int exp_lat, input int ch,
                              input bit hit, input bit err, input int idx,
                              input logic [31:0] data, input int num);
        check({tag, "_lat"},  64'(lat),              64'(exp_lat));
        check({tag, "_ch"},   64'(bus.rsp_ch),       64'(ch));
        check({tag, "_hit"},  64'(bus.rsp_hit),      64'(hit));
        check({tag, "_err"},  64'(bus.rsp_err),      64'(err));
        check({tag, "_idx"},  64'(bus.rsp_idx),      64'(idx));
        check({tag, "_data"}, 64'(bus.rsp_data),     64'(data));
        check({tag, "_num"},  64'(bus.num_entries),  64'(num));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wacc, ng, nr;
        int grants [4];
        int rchs   [4];

        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_name  = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;

        reset_dut();
        check("rst_req_ready", 64'(bus.req_ready),   64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid),   64'd0);
        check("rst_num",       64'(bus.num_entries), 64'd0);
        check("rst_rsp_ch",    64'(bus.rsp_ch),      64'd0);
        check("rst_rsp_hit",   64'(bus.rsp_hit),     64'd0);
        check("rst_rsp_err",   64'(bus.rsp_err),     64'd0);
        check("rst_rsp_idx",   64'(bus.rsp_idx),     64'd0);
        check("rst_rsp_data",  64'(bus.rsp_data),    64'd0);

        // GET on empty table misses after a full scan.
        do_req(0, 1'b0, 16'h1234, 32'h0, lat, wacc);
        check("get0_wait", 64'(wacc), 64'd0);
        expect_rsp("get0", lat, MISS_LAT, 0, 1'b0, 1'b0, 0, 32'h0, 0);
        finish_rsp();

        // SET allocates slot 0, GET then hits at index 0.
        do_req(1, 1'b1, 16'h1234, 32'hDEADBEEF, lat, wacc);
        expect_rsp("set1", lat, MISS_LAT, 1, 1'b0, 1'b0, 0, 32'hDEADBEEF, 1);
        finish_rsp();
        do_req(0, 1'b0, 16'h1234, 32'h0, lat, wacc);
        check("b2b_wait", 64'(wacc), 64'd0);
        expect_rsp("get1", lat, 2, 0, 1'b1, 1'b0, 0, 32'hDEADBEEF, 1);
        finish_rsp();

        // Overwrite existing name.
        do_req(0, 1'b1, 16'h1234, 32'hCAFE0000, lat, wacc);
        expect_rsp("set2", lat, 2, 0, 1'b1, 1'b0, 0, 32'hCAFE0000, 1);
        finish_rsp();
        do_req(1, 1'b0, 16'h1234, 32'h0, lat, wacc);
        expect_rsp("get2", lat, 2, 1, 1'b1, 1'b0, 0, 32'hCAFE0000, 1);
        finish_rsp();

        // Fill remaining slots 1..DEPTH-1.
        for (int i = 1; i < DEPTH; i++) begin
            do_req(i % 2, 1'b1, 16'(16'h1000 + i), 32'(32'hA0000000 + i), lat, wacc);
            expect_rsp($sformatf("fill%0d", i), lat, MISS_LAT, i % 2, 1'b0, 1'b0, i,
                       32'(32'hA0000000 + i), i + 1);
            finish_rsp();
        end

        // Table full: new name errors, nothing changes.
        do_req(0, 1'b1, 16'h9999, 32'h55555555, lat, wacc);
        expect_rsp("full", lat, MISS_LAT, 0, 1'b0, 1'b1, 0, 32'h0, DEPTH);
        finish_rsp();
        do_req(1, 1'b0, 16'h1005, 32'h0, lat, wacc);
        expect_rsp("keep5", lat, 7, 1, 1'b1, 1'b0, 5, 32'hA0000005, DEPTH);
        finish_rsp();
        do_req(0, 1'b0, 16'h1234, 32'h0, lat, wacc);
        expect_rsp("keep0", lat, 2, 0, 1'b1, 1'b0, 0, 32'hCAFE0000, DEPTH);
        finish_rsp();
        do_req(0, 1'b0, 16'h9999, 32'h0, lat, wacc);
        expect_rsp("nofull", lat, MISS_LAT, 0, 1'b0, 1'b0, 0, 32'h0, DEPTH);
        finish_rsp();

        // Response held stable while rsp_ready stays low.
        do_req(1, 1'b0, 16'h100F, 32'h0, lat, wacc);
        expect_rsp("last", lat, 17, 1, 1'b1, 1'b0, 15, 32'hA000000F, DEPTH);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d_valid", i), 64'(bus.rsp_valid), 64'd1);
            check($sformatf("hold%0d_ch", i),    64'(bus.rsp_ch),    64'd1);
            check($sformatf("hold%0d_idx", i),   64'(bus.rsp_idx),   64'd15);
            check($sformatf("hold%0d_data", i),  64'(bus.rsp_data),  64'hA000000F);
        end
        finish_rsp();

        // Reset during scan drops the request and clears the table.
        @(negedge clk);
        bus.req_valid[0]                 = 1'b1;
        bus.req_op[0]                    = 1'b0;
        bus.req_name[0 +: NAME_W]        = 16'h100F;
        #1;
        check("rs_accept", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rs_rsp_valid", 64'(bus.rsp_valid),   64'd0);
        check("rs_num",       64'(bus.num_entries), 64'd0);
        do_req(0, 1'b0, 16'h1234, 32'h0, lat, wacc);
        check("rs_wait", 64'(wacc), 64'd0);
        expect_rsp("rs_get", lat, MISS_LAT, 0, 1'b0, 1'b0, 0, 32'h0, 0);
        finish_rsp();

        // Round-robin with both channels valid and rsp_ready high.
        reset_dut();
        ng = 0;
        nr = 0;
        bus.req_valid             = 2'b11;
        bus.req_op                = 2'b00;
        bus.req_name[0 +: NAME_W] = 16'h2000;
        bus.req_name[NAME_W +: NAME_W] = 16'h2001;
        bus.rsp_ready             = 1'b1;
        for (int c = 0; c < 300 && nr < 3; c++) begin
            #1;
            if (bus.req_ready != '0) begin
                check("rr_onehot", 64'($countones(bus.req_ready)), 64'd1);
                if (ng < 4) grants[ng] = bus.req_ready[1] ? 1 : 0;
                ng++;
            end
            if (bus.rsp_valid) begin
                check("rr_hit", 64'(bus.rsp_hit), 64'd0);
                if (nr < 4) rchs[nr] = int'(bus.rsp_ch);
                nr++;
                if (nr == 3) bus.req_valid = '0;
            end
            if (nr < 3) @(negedge clk);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check("rr_nresp",  64'(nr), 64'd3);
        check("rr_ngrant", 64'(ng), 64'd3);
        if (ng >= 3 && nr >= 3) begin
            check("rr_grant0", 64'(grants[0]), 64'd0);
            check("rr_grant1", 64'(grants[1]), 64'd1);
            check("rr_grant2", 64'(grants[2]), 64'd0);
            check("rr_ch0",    64'(rchs[0]),   64'd0);
            check("rr_ch1",    64'(rchs[1]),   64'd1);
            check("rr_ch2",    64'(rchs[2]),   64'd0);
        end
        @(negedge clk);
        check("end_idle_valid", 64'(bus.rsp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
